// File: rtl/scroll_obj_engine.sv
// rtl/scroll_obj_engine.sv - fine/coarse scroll, NUM_OBJ object channels, collision and tile RAM writer
// Optional feature macro: OBJ_BOB_EN (per-step +/-1 row bob of active objects)
module scroll_obj_engine #(
  parameter int NUM_OBJ    = 4,
  parameter int TILE_COLS  = 40,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DELAY_W    = 32,
  parameter int MAX_DELAY  = 1000000,
  parameter int MIN_DELAY  = 200000,
  parameter int SPEED_STEP = 100000,
  parameter int SPAWN_BASE = 40,
  parameter int SPAWN_SPAN = 8,
  parameter int ROW_MIN    = 23,
  parameter int ROW_SPAN   = 4,
  parameter int PLAYER_W   = 28,
  parameter int PLAYER_H   = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  input  logic                      freeze,
  input  logic                      speed_up,
  input  logic [9:0]                player_x,
  input  logic [9:0]                player_y,
  input  logic [NUM_OBJ*DATA_W-1:0] obj_tile,
  output logic [3:0]                scroll_offset,
  output logic                      step_pulse,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_data,
  output logic [NUM_OBJ-1:0]        hit,
  output logic [NUM_OBJ-1:0]        obj_active,
  output logic [DELAY_W-1:0]        scroll_delay
);

  localparam int                 IDX_W     = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_OBJ - 1);
  localparam logic [7:0]         COLS_P    = 8'(TILE_COLS);
  localparam logic [ADDR_W-1:0]  COLS_A    = ADDR_W'(TILE_COLS);
  localparam logic [DELAY_W-1:0] MAX_D     = DELAY_W'(MAX_DELAY);
  localparam logic [DELAY_W-1:0] MIN_D     = DELAY_W'(MIN_DELAY);
  localparam logic [DELAY_W-1:0] STEP_D    = DELAY_W'(SPEED_STEP);
  localparam logic [DELAY_W:0]   FLOOR_SUM = (DELAY_W+1)'(MIN_DELAY) + (DELAY_W+1)'(SPEED_STEP);

  typedef enum logic [1:0] {W_IDLE, W_ERASE, W_DRAW} wr_state_t;

  logic [DELAY_W-1:0] tick_cnt;
  logic [15:0]        lfsr;
  logic               step_pending;
  logic               hit_pending;
  logic [7:0]         x  [NUM_OBJ];
  logic [7:0]         y  [NUM_OBJ];
  logic [7:0]         ox [NUM_OBJ];
  logic [7:0]         oy [NUM_OBJ];
  logic [15:0]        rot     [NUM_OBJ];
  logic [7:0]         spawn_x [NUM_OBJ];
  logic [7:0]         spawn_y [NUM_OBJ];
  wr_state_t          wr_state;
  logic [IDX_W-1:0]   wr_idx;
`ifdef OBJ_BOB_EN
  logic [NUM_OBJ-1:0] phase;
`endif

  logic               tick_hit;
  logic               wrap;
  logic               step_go;
  logic               hit_go;
  logic [NUM_OBJ-1:0] respawn_now;
  logic [NUM_OBJ-1:0] hit_now;
  logic [15:0]        px_lo, px_hi, py_lo, py_hi;
  logic [7:0]         wr_col, wr_row;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  draw_tile;

  function automatic logic [15:0] rotl(input logic [15:0] v, input int s);
    return (v << s) | (v >> (16 - s));
  endfunction

  assign tick_hit = run && !freeze && (tick_cnt >= scroll_delay);
  assign wrap     = tick_hit && (scroll_offset == 4'hF);
  // A pending step always takes the writer first; its sweep also redraws hit channels.
  assign step_go  = step_pending && (wr_state == W_IDLE);
  assign hit_go   = hit_pending && !step_pending && (wr_state == W_IDLE);

  assign px_lo = {6'd0, player_x} + {12'd0, scroll_offset};
  assign px_hi = px_lo + 16'(PLAYER_W);
  assign py_lo = {6'd0, player_y};
  assign py_hi = py_lo + 16'(PLAYER_H);

  always_comb begin
    for (int i = 0; i < NUM_OBJ; i++) begin
      rot[i]     = rotl(lfsr, (3 * i) % 16);
      spawn_x[i] = 8'(SPAWN_BASE) + 8'(rot[i] & 16'(SPAWN_SPAN - 1));
      spawn_y[i] = 8'(ROW_MIN) + 8'((rot[i] >> 4) & 16'(ROW_SPAN - 1));
    end
  end

  always_comb begin
    respawn_now = '0;
    hit_now     = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      respawn_now[i] = step_go && (x[i] == 8'd0);
      hit_now[i] = obj_active[i] && (x[i] < COLS_P) && run && !freeze && !respawn_now[i]
                   && (px_hi >= {4'd0, x[i], 4'd0})
                   && (px_lo <  ({4'd0, x[i], 4'd0} + 16'd16))
                   && (py_hi >= {4'd0, y[i], 4'd0})
                   && (py_lo <  ({4'd0, y[i], 4'd0} + 16'd16));
    end
  end

  always_comb begin
    wr_col = ox[wr_idx];
    wr_row = oy[wr_idx];
    if (wr_state == W_DRAW) begin
      wr_col = x[wr_idx];
      wr_row = y[wr_idx];
    end
    wr_addr   = ADDR_W'(wr_row) * COLS_A + ADDR_W'(wr_col);
    draw_tile = obj_tile[wr_idx*DATA_W +: DATA_W];
    draw_tile[DATA_W-8] = obj_active[wr_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt      <= '0;
      scroll_offset <= 4'd0;
      step_pulse    <= 1'b0;
      scroll_delay  <= MAX_D;
    end else begin
      step_pulse <= 1'b0;
      if (run && !freeze) begin
        if (tick_hit) begin
          tick_cnt      <= '0;
          scroll_offset <= scroll_offset + 4'd1;
          if (scroll_offset == 4'hF) step_pulse <= 1'b1;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
      if (speed_up && !freeze) begin
        if ({1'b0, scroll_delay} >= FLOOR_SUM) scroll_delay <= scroll_delay - STEP_D;
        else                                   scroll_delay <= MIN_D;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    lfsr <= 16'hACE1;
    else if (run) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        x[i]  <= 8'(SPAWN_BASE + i * SPAWN_SPAN);
        y[i]  <= 8'(ROW_MIN);
        ox[i] <= 8'(SPAWN_BASE + i * SPAWN_SPAN);
        oy[i] <= 8'(ROW_MIN);
      end
      obj_active   <= '1;
      hit          <= '0;
      step_pending <= 1'b0;
      hit_pending  <= 1'b0;
      wr_state     <= W_IDLE;
      wr_idx       <= '0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_data     <= '0;
`ifdef OBJ_BOB_EN
      phase        <= '0;
`endif
    end else begin
      hit <= hit_now;
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (step_go || hit_go) begin
          ox[i] <= x[i];
          oy[i] <= y[i];
        end
        if (respawn_now[i]) begin
          x[i]          <= spawn_x[i];
          y[i]          <= spawn_y[i];
          obj_active[i] <= 1'b1;
`ifdef OBJ_BOB_EN
          phase[i]      <= 1'b0;
`endif
        end else begin
          if (step_go) begin
            x[i] <= x[i] - 8'd1;
`ifdef OBJ_BOB_EN
            if (obj_active[i]) begin
              y[i]     <= phase[i] ? (y[i] - 8'd1) : (y[i] + 8'd1);
              phase[i] <= ~phase[i];
            end
`endif
          end
          if (hit_now[i]) obj_active[i] <= 1'b0;
        end
      end

      if (step_go) begin
        step_pending <= 1'b0;
        hit_pending  <= 1'b0;
      end else if (hit_go) begin
        hit_pending <= 1'b0;
      end
      if (wrap)      step_pending <= 1'b1;
      if (|hit_now)  hit_pending  <= 1'b1;

      // Off-screen columns still take their slot so the sweep length is fixed.
      case (wr_state)
        W_IDLE: begin
          ram_we   <= 1'b0;
          ram_data <= '0;
          if (step_go || hit_go) begin
            wr_state <= W_ERASE;
            wr_idx   <= '0;
          end
        end
        W_ERASE: begin
          ram_we   <= (wr_col < COLS_P);
          ram_addr <= wr_addr;
          ram_data <= '0;
          wr_state <= W_DRAW;
        end
        W_DRAW: begin
          ram_we   <= (wr_col < COLS_P);
          ram_addr <= wr_addr;
          ram_data <= draw_tile;
          if (wr_idx == LAST_IDX) begin
            wr_state <= W_IDLE;
          end else begin
            wr_idx   <= wr_idx + 1'b1;
            wr_state <= W_ERASE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: doc/scroll_obj_engine.md
Name: scroll_obj_engine

Overview:
Parametrised scrolling-object engine for the side-scrolling runner. It generates the fine/coarse background scroll and runs NUM_OBJ independent object channels (coins, ghosts, ...). Each channel scrolls left, respawns pseudo-randomly, and is collision-checked against the player. Changed object tiles are written into background tile RAM through a single sequential write port; the port sits beside the floor/score writers on the BG RAM mux.

Parameters:
NUM_OBJ, 4, number of object channels (1..8)
TILE_COLS, 40, tile columns on screen
DATA_W, 16, tile RAM word width
ADDR_W, 16, tile RAM address width
DELAY_W, 32, scroll delay counter width
MAX_DELAY, 1000000, scroll delay after reset (clk cycles per pixel)
MIN_DELAY, 200000, scroll delay floor; must be >= 2*NUM_OBJ+4
SPEED_STEP, 100000, delay decrement per speed_up
SPAWN_BASE, 40, respawn column base
SPAWN_SPAN, 8, respawn column random span; power of 2
ROW_MIN, 23, respawn row base
ROW_SPAN, 4, respawn row random span; power of 2
PLAYER_W, 28, player box width in px
PLAYER_H, 32, player box height in px

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
run  in  1  game running; low freezes scroll, collision and LFSR
freeze  in  1  game over; stops scroll, hits and speed_up
speed_up  in  1  one-cycle pulse: shorten scroll delay
player_x  in  10  player screen x, px
player_y  in  10  player screen y, px
obj_tile  in  NUM_OBJ*DATA_W  tile word drawn for channel i, at slice [i*DATA_W +: DATA_W]
scroll_offset  out  4  fine pixel scroll, 0..15
step_pulse  out  1  one cycle on coarse tile step
ram_we  out  1  tile RAM write enable
ram_addr  out  ADDR_W  tile RAM address, y*TILE_COLS+x
ram_data  out  DATA_W  tile RAM write data
hit  out  NUM_OBJ  one-cycle collision pulse per channel
obj_active  out  NUM_OBJ  channel visible and collidable
scroll_delay  out  DELAY_W  current delay

Behaviour:
- Reset (async): all outputs 0 except scroll_delay=MAX_DELAY and obj_active=all 1. Channel i initialises to x=SPAWN_BASE+i*SPAWN_SPAN, y=ROW_MIN. LFSR=16'hACE1. Writer is IDLE.
- Tick counter:
  - Counts up while run && !freeze.
  - When the count equals scroll_delay: count<=0 and scroll_offset<=scroll_offset+1 (wraps 15->0).
  - On the 15->0 wrap: step_pulse=1 for one cycle and the step_pending flag is set.
- Coarse step: applied only when step_pending && writer IDLE. On that cycle, for each channel:
  - old position is latched (ox,oy);
  - if x>0: x<=x-1;
  - else respawn: x<=SPAWN_BASE+(r mod SPAWN_SPAN), y<=ROW_MIN+((r>>4) mod ROW_SPAN), active<=1.
  - r is the LFSR rotated left by 3*i.
  - step_pending is cleared and the writer starts a sweep.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle while run.
- Writer FSM:
  - IDLE -> ERASE(0) -> DRAW(0) -> ERASE(1) -> ... -> DRAW(NUM_OBJ-1) -> IDLE, one cycle per state.
  - ERASE: addr=oy*TILE_COLS+ox, data=0.
  - DRAW: addr=y*TILE_COLS+x, data=obj_tile slice with bit DATA_W-8 forced to active.
  - ram_we=1 only when the column in use is < TILE_COLS; otherwise the state still advances with ram_we=0.
  - ram_we, ram_addr and ram_data are registered outputs.
  - The writer completes an in-progress sweep even if run drops.
- Hit sweep: a hit requests a sweep with no movement (ox=x, oy=y). It is queued by a hit_pending flag when the writer is busy. If a step and a hit are both pending, the step wins and its sweep also covers the cleared channel.
- Collision: evaluated every cycle for channels with active && x<TILE_COLS && run && !freeze. Hit condition, all using unsigned 16-bit arithmetic:
  - player_x+scroll_offset+PLAYER_W >= x*16
  - player_x+scroll_offset < (x+1)*16
  - player_y+PLAYER_H >= y*16
  - player_y < (y+1)*16
  - On a hit: hit[i] is registered for 1 cycle and active[i]<=0. No repeat hit until respawn.
- Speed: speed_up && !freeze gives scroll_delay<=max(scroll_delay-SPEED_STEP, MIN_DELAY), saturating with no underflow.
- Simultaneous events:
  - Tick-count equality with speed_up: the compare uses the old delay.
  - Respawn and collision on the same cycle: respawn wins (active=1, no hit).

Optional Feature:
OBJ_BOB_EN: when defined, each active channel's y alternates +1/-1 on every coarse step, using a per-channel phase bit. The phase resets to 0 and clears on respawn. The erase uses the latched old y. When undefined, y changes only on respawn.

Test Plan:
- Params MAX_DELAY=4, MIN_DELAY=12, SPEED_STEP=2, run=1: scroll_offset advances every 5 cycles, and step_pulse occurs 80 cycles after reset -> channel 0 x goes 40->39, followed by 8 writes.
- After the first step: ERASE(0) writes addr=23*40+40 with ram_we=0 (column out of range); DRAW(0) writes addr=23*40+39=959 with obj_tile[15:0] and ram_we=1.
- Channel at x=10, y=23, scroll_offset=0; set player_x=150, player_y=340 -> hit[0] pulses for exactly 1 cycle, obj_active[0]=0, and a sweep writes 0 to addr 930.
- Repeated speed_up from MAX_DELAY=1000000 -> delay goes 900000, ..., 200000 and stays at 200000 after the 9th pulse; any pulse with freeze=1 leaves it unchanged.
- Channel at x=0 on a coarse step -> x in 40..47, y in 23..26, active=1; reset asserted mid-sweep -> ram_we drops to 0 immediately and all state reinitialises.
- run=0 for 100 cycles -> scroll_offset, LFSR and hit are frozen; an in-progress sweep still completes all 2*NUM_OBJ states.
